// File: rtl/reception_dispatcher.sv
// Two-doctor reception desk: FIFO of patient check-ins with sequential tokens,
// head-of-line dispatch to free doctors and per-doctor consultation timers.
module reception_dispatcher #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TOKEN_W   = 8,
   parameter int unsigned CONSULT_A = 10,
   parameter int unsigned CONSULT_B = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               query,
   output logic                     A,
   output logic                     B,
   output logic [1:0]               msg,
   output logic                     assign_valid,
   output logic [TOKEN_W-1:0]       token_out,
   output logic [TOKEN_W-1:0]       token_in,
   output logic                     reject,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned CA_W  = (CONSULT_A > 1) ? $clog2(CONSULT_A) : 1;
   localparam int unsigned CB_W  = (CONSULT_B > 1) ? $clog2(CONSULT_B) : 1;

   typedef enum logic [0:0] {StIdle, StConsult} doc_state_e;

   logic [1:0]         pref_q [DEPTH];
   logic [TOKEN_W-1:0] tok_q  [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TOKEN_W-1:0] tok_cnt_q;

   doc_state_e         state_a_q, state_a_d, state_b_q, state_b_d;
   logic [CA_W-1:0]    cnt_a_q, cnt_a_d;
   logic [CB_W-1:0]    cnt_b_q, cnt_b_d;

   logic               req, push, rej, pop, give_a, give_b;
   logic [1:0]         head_pref;
   logic [TOKEN_W-1:0] head_tok;

   assign full        = (count_q == CNT_W'(DEPTH));
   assign empty       = (count_q == '0);
   assign queue_count = count_q;

   // A check-in is judged against the registered full flag only.
   assign req  = start && (query != 2'b00);
   assign push = req && !full;
   assign rej  = req && full;

   assign head_pref = pref_q[rd_ptr_q];
   assign head_tok  = tok_q[rd_ptr_q];

   // Strict FIFO: only the head is considered; "either" prefers doctor A.
   always_comb begin
      give_a = 1'b0;
      give_b = 1'b0;
      if (!empty) begin
         if (head_pref[0] && !A) begin
            give_a = 1'b1;
         end else if (head_pref[1] && !B) begin
            give_b = 1'b1;
         end
      end
   end

   assign pop = give_a || give_b;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pref_q[i] <= 2'b00;
            tok_q[i]  <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         tok_cnt_q    <= '0;
         token_in     <= '0;
         token_out    <= '0;
         msg          <= 2'b00;
         assign_valid <= 1'b0;
         reject       <= 1'b0;
      end else begin
         count_q      <= count_d;
         reject       <= rej;
         assign_valid <= pop;
         if (push) begin
            pref_q[wr_ptr_q] <= query;
            tok_q[wr_ptr_q]  <= tok_cnt_q;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            token_in         <= tok_cnt_q;
            tok_cnt_q        <= tok_cnt_q + TOKEN_W'(1);
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            token_out <= head_tok;
            msg       <= give_a ? 2'b10 : 2'b01;
         end else begin
            msg <= 2'b00;
         end
      end
   end

   // Doctor timers: state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_a_q <= StIdle;
         state_b_q <= StIdle;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
      end else begin
         state_a_q <= state_a_d;
         state_b_q <= state_b_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
      end
   end

   // Busy lasts exactly CONSULT_x cycles: load CONSULT_x-1, release on zero.
   always_comb begin
      state_a_d = state_a_q;
      cnt_a_d   = cnt_a_q;
      unique case (state_a_q)
         StIdle: begin
            if (give_a) begin
               state_a_d = StConsult;
               cnt_a_d   = CA_W'(CONSULT_A - 1);
            end
         end
         StConsult: begin
            if (cnt_a_q == '0) begin
               state_a_d = StIdle;
            end else begin
               cnt_a_d = cnt_a_q - CA_W'(1);
            end
         end
         default: state_a_d = StIdle;
      endcase

      state_b_d = state_b_q;
      cnt_b_d   = cnt_b_q;
      unique case (state_b_q)
         StIdle: begin
            if (give_b) begin
               state_b_d = StConsult;
               cnt_b_d   = CB_W'(CONSULT_B - 1);
            end
         end
         StConsult: begin
            if (cnt_b_q == '0) begin
               state_b_d = StIdle;
            end else begin
               cnt_b_d = cnt_b_q - CB_W'(1);
            end
         end
         default: state_b_d = StIdle;
      endcase
   end

   always_comb begin
      A = (state_a_q == StConsult);
      B = (state_b_q == StConsult);
   end

endmodule

// File: tb/tb_reception_dispatcher.sv
// Scoreboard bench for reception_dispatcher: stimulus queues expected assignments,
// a negedge monitor pops and compares on every assign_valid pulse.
module tb_reception_dispatcher;

   logic       clk, rst, start;
   logic [1:0] query;
   logic       A, B, assign_valid, reject, full, empty;
   logic [1:0] msg;
   logic [7:0] token_out, token_in;
   logic [3:0] queue_count;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [9:0] exp_q [$];
   logic [9:0] e;

   reception_dispatcher #(
      .DEPTH(8), .TOKEN_W(8), .CONSULT_A(10), .CONSULT_B(6)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .query(query),
      .A(A), .B(B), .msg(msg), .assign_valid(assign_valid),
      .token_out(token_out), .token_in(token_in), .reject(reject),
      .queue_count(queue_count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (assign_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_assign: got msg %0b token %0d expected none",
                        msg, token_out);
            end else begin
               e = exp_q.pop_front();
               check("assign_msg", {30'd0, msg}, {30'd0, e[9:8]});
               check("assign_token", {24'd0, token_out}, {24'd0, e[7:0]});
            end
         end else begin
            check("idle_msg", {30'd0, msg}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkin(input logic [1:0] q);
      start = 1'b1;
      query = q;
      @(negedge clk);
      start = 1'b0;
      query = 2'b00;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(empty && !A && !B) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
      end
   endtask

   initial begin
      int cnt;
      int it;
      rst   = 1'b1;
      start = 1'b0;
      query = 2'b00;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_A", {31'd0, A}, 32'd0);
      check("rst_B", {31'd0, B}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_count", {28'd0, queue_count}, 32'd0);
      check("rst_token_in", {24'd0, token_in}, 32'd0);
      check("rst_reject", {31'd0, reject}, 32'd0);

      // Single patient to A, busy exactly 10 cycles
      exp_q.push_back({2'b10, 8'd0});
      checkin(2'b01);
      check("single_token_in", {24'd0, token_in}, 32'd0);
      check("single_count", {28'd0, queue_count}, 32'd1);
      tick();
      cnt = 0;
      while (A && cnt < 40) begin
         cnt++;
         tick();
      end
      check("single_A_cycles", cnt, 32'd10);

      // Asynchronous reset mid-consult
      exp_q.push_back({2'b10, 8'd1});
      checkin(2'b01);
      tick();
      tick();
      tick();
      tick();
      check("pre_rst_A", {31'd0, A}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_A", {31'd0, A}, 32'd0);
      check("async_rst_empty", {31'd0, empty}, 32'd1);
      check("async_rst_count", {28'd0, queue_count}, 32'd0);
      check("async_rst_token_in", {24'd0, token_in}, 32'd0);
      tick();
      rst = 1'b0;
      exp_q.push_back({2'b10, 8'd0});
      checkin(2'b01);
      check("post_rst_token", {24'd0, token_in}, 32'd0);
      wait_idle();

      // Either-preference spill to B
      exp_q.push_back({2'b10, 8'd1});
      exp_q.push_back({2'b01, 8'd2});
      checkin(2'b11);
      checkin(2'b11);
      tick();
      check("spill_A", {31'd0, A}, 32'd1);
      check("spill_B", {31'd0, B}, 32'd1);
      wait_idle();

      // Head-of-line block: B-only patient waits behind A-only patient
      exp_q.push_back({2'b10, 8'd3});
      exp_q.push_back({2'b10, 8'd4});
      exp_q.push_back({2'b01, 8'd5});
      checkin(2'b01);
      checkin(2'b01);
      checkin(2'b10);
      tick();
      tick();
      check("hol_A", {31'd0, A}, 32'd1);
      check("hol_B", {31'd0, B}, 32'd0);
      check("hol_count", {28'd0, queue_count}, 32'd2);
      wait_idle();

      // Fill queue behind busy A, then reject (including same-edge dispatch)
      exp_q.push_back({2'b10, 8'd6});
      checkin(2'b01);
      tick();
      for (int i = 7; i <= 14; i++) begin
         exp_q.push_back({2'b10, 8'(i)});
         checkin(2'b01);
      end
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_count", {28'd0, queue_count}, 32'd8);
      check("fill_token_in", {24'd0, token_in}, 32'd14);
      it = 0;
      do begin
         checkin(2'b01);
         it++;
         check("full_reject", {31'd0, reject}, 32'd1);
         check("full_token_hold", {24'd0, token_in}, 32'd14);
      end while (queue_count == 4'd8 && it < 20);
      check("full_reject_iters", it, 32'd3);
      check("count_after_pop", {28'd0, queue_count}, 32'd7);
      tick();
      check("reject_pulse_end", {31'd0, reject}, 32'd0);
      wait_idle();

      // Token wrap after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 255; i++) begin
         exp_q.push_back({2'b10, 8'(i)});
         checkin(2'b11);
         check("wrap_token_seq", {24'd0, token_in}, i);
         wait_idle();
      end
      exp_q.push_back({2'b10, 8'd255});
      exp_q.push_back({2'b01, 8'd0});
      checkin(2'b11);
      check("wrap_token_255", {24'd0, token_in}, 32'd255);
      checkin(2'b11);
      check("wrap_token_0", {24'd0, token_in}, 32'd0);
      tick();
      check("wrap_A", {31'd0, A}, 32'd1);
      check("wrap_B", {31'd0, B}, 32'd1);
      wait_idle();
      tick();
      tick();
      check("pending_expected", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/reception_dispatcher.md
Name: reception_dispatcher

Overview:
- Patient-queue scheduler for the two-doctor reception desk.
- Accepts patient check-ins with a doctor preference and stores them in a strict FIFO with sequential token numbers.
- Assigns the head patient to a free doctor and times each consultation to generate the doctor busy flags A and B.
- Replaces the free-running availability counters with demand-driven sequencing.

Parameters:
- DEPTH, 8: waiting-queue entries (power of 2, ≥2).
- TOKEN_W, 8: token number width.
- CONSULT_A, 10: cycles doctor A stays busy per patient (≥1).
- CONSULT_B, 6: cycles doctor B stays busy per patient (≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  check-in strobe, sampled each rising edge.
- query  input  2  preference: 01=A only, 10=B only, 11=either, 00=no request.
- A  output  1  doctor A busy.
- B  output  1  doctor B busy.
- msg  output  2  assignment: 10=to A, 01=to B, 00=none; 11 never driven.
- assign_valid  output  1  one-cycle pulse; msg/token_out valid.
- token_out  output  TOKEN_W  token of the patient being assigned.
- token_in  output  TOKEN_W  token given to the last accepted check-in.
- reject  output  1  one-cycle pulse: check-in refused (queue full).
- queue_count  output  log2(DEPTH)+1  entries waiting.
- full  output  1  queue_count==DEPTH.
- empty  output  1  queue_count==0.

Behaviour:
- Reset: all outputs 0 (empty=1), queue cleared, token counter 0, both timers 0. Applies immediately, mid-operation included; in-flight consultations and queued patients are discarded.
- Check-in (edge with start=1):
  - query==00: ignored, no reject.
  - Otherwise, if registered full==0: push {query, token counter}; token_in<=token counter; counter increments, wrapping modulo 2^TOKEN_W.
  - If full==1: reject<=1; no push; counter unchanged.
  - Full is the registered value. A same-edge dispatch does not make room for a simultaneous check-in: the check-in is rejected.
- Dispatch (every edge, strict FIFO, no bypass of head). Uses registered A/B and the registered queue state.
  - Head 01: assign if A==0.
  - Head 10: assign if B==0.
  - Head 11: A if A==0, else B if B==0.
  - If the head cannot be served, the queue stalls, even if later entries could be.
  - On assignment: pop head; assign_valid<=1; msg<=10 or 01; token_out<=head token.
  - Otherwise: assign_valid<=0, msg<=00; token_out holds its last value.
- Latency:
  - A patient pushed at edge N is dispatchable at edge N+1 at the earliest.
  - A simultaneous push and pop leaves queue_count unchanged.
- Consult timer (A shown; B identical with CONSULT_B):
  - On the assigning edge: A<=1, cnt_a<=CONSULT_A-1.
  - On each later edge with A==1: if cnt_a==0 then A<=0, else cnt_a decrements.
  - A is therefore high for exactly CONSULT_A cycles.
  - A doctor released at edge M is assignable at edge M+1.
  - Only one assignment per edge, so A and B are never set on the same edge.
- State per doctor: IDLE (busy=0) → CONSULT (busy=1, counting) → IDLE on timer expiry. No other transitions except reset.
- Queue pointers wrap modulo DEPTH. queue_count never exceeds DEPTH and never underflows.

Test Plan:
- Reset mid-consult: assign to A, pulse rst after 3 cycles → A=0, empty=1, queue_count=0, token_in=0 asynchronously. The next check-in gets token 0.
- Single patient: start with query=01 at edge 1 → edge 2: assign_valid=1, msg=10, token_out=0. A high for exactly 10 cycles (CONSULT_A=10), then 0.
- Either-preference spill: two back-to-back check-ins with query=11 → first gets msg=10. Second gets msg=01 one edge later. A and B are both high during the overlap.
- Head-of-line block: A busy; queue 01 then 10 with B free → no assignment until A releases. Then the 01 patient goes to A, and next edge the 10 patient goes to B.
- Full/reject: both doctors busy, 8 check-ins fill the queue (full=1). Ninth check-in → reject=1, token counter unchanged. A check-in on the same edge as a dispatch while full is also rejected.
- Token wrap: 256 accepted check-ins → token_in sequence 0..255. The 257th check-in gets token 0, with correct FIFO order maintained.
